// File: rtl/event_buffer.sv
// event_buffer: frame FIFO between trigger capture and SPI readout.
// Each accepted trigger is packed into a 128-bit frame and queued. The oldest
// frame is presented on a registered output together with an active-low MCU
// interrupt. Optional build macro EVENT_BUFFER_DROP_TAG_EN puts the number of
// triggers dropped since the previous stored frame into frame bits [15:8].
// The reference counter input is named ref_counter because "ref" is a
// SystemVerilog keyword.
module event_buffer #(
  parameter int         DEPTH      = 8,
  parameter logic [7:0] START_BYTE = 8'h7E,
  parameter logic [7:0] END_BYTE   = 8'h7D
) (
  input  logic                     sampling_clk,
  input  logic                     reset,
  input  logic                     trig_valid,
  input  logic [15:0]              trigger_id,
  input  logic [63:0]              ref_counter,
  input  logic [23:0]              data_in,
  input  logic                     flush,
  input  logic                     frame_ack,
  output logic [127:0]             frame,
  output logic                     frame_valid,
  output logic                     interrupt,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam logic [127:0]    IDLE_FRAME = {START_BYTE, 112'h0, END_BYTE};

  logic [127:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [7:0]    tag_bits;
  logic [127:0]  new_frame;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // An ack only counts while a head is shown; flush overrides both ack and write.
  assign pop   = frame_ack & frame_valid & ~flush;
  assign wr_en = trig_valid & ~flush & (~full | pop);
  assign drop  = trig_valid & ~flush & full & ~pop;

`ifdef EVENT_BUFFER_DROP_TAG_EN
  logic [7:0] drop_tag;

  // Drops since the last stored frame; the stored frame carries the value, then it clears.
  always_ff @(posedge sampling_clk or posedge reset) begin
    if (reset) begin
      drop_tag <= 8'h00;
    end else if (wr_en) begin
      drop_tag <= 8'h00;
    end else if (drop && (drop_tag != 8'hFF)) begin
      drop_tag <= drop_tag + 8'h01;
    end
  end

  assign tag_bits = drop_tag;
`else
  assign tag_bits = 8'h00;
`endif

  assign new_frame = {START_BYTE, trigger_id, ref_counter, data_in, tag_bits, END_BYTE};

  // Frame storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge sampling_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= new_frame;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge sampling_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating count of triggers lost to a full buffer; flush leaves it alone.
  always_ff @(posedge sampling_clk or posedge reset) begin
    if (reset) begin
      drop_count <= 8'h00;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'h01;
    end
  end

  // Registered head frame: a pop or flush forces one idle cycle before the next head.
  always_ff @(posedge sampling_clk or posedge reset) begin
    if (reset) begin
      frame       <= IDLE_FRAME;
      frame_valid <= 1'b0;
      interrupt   <= 1'b1;
    end else if (flush || pop || empty) begin
      frame       <= IDLE_FRAME;
      frame_valid <= 1'b0;
      interrupt   <= 1'b1;
    end else begin
      frame       <= mem[rd_ptr];
      frame_valid <= 1'b1;
      interrupt   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_buffer.sv
// Scoreboard bench for event_buffer: stimulus queues expected head frames,
// a negedge monitor compares each newly presented head against the queue.
module tb_event_buffer;

  localparam int DEPTH = 8;
`ifdef EVENT_BUFFER_DROP_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam logic [127:0] IDLE = {8'h7E, 112'h0, 8'h7D};

  logic         sampling_clk;
  logic         reset;
  logic         trig_valid;
  logic [15:0]  trigger_id;
  logic [63:0]  ref_v;
  logic [23:0]  data_in;
  logic         flush;
  logic         frame_ack;
  logic [127:0] frame;
  logic         frame_valid;
  logic         interrupt;
  logic [3:0]   count;
  logic [7:0]   drop_count;

  int checks = 0;
  int failures = 0;
  logic [127:0] sb [$];
  bit prev_fv = 1'b0;

  event_buffer #(.DEPTH(DEPTH)) dut (
    .sampling_clk (sampling_clk),
    .reset        (reset),
    .trig_valid   (trig_valid),
    .trigger_id   (trigger_id),
    .ref_counter  (ref_v),
    .data_in      (data_in),
    .flush        (flush),
    .frame_ack    (frame_ack),
    .frame        (frame),
    .frame_valid  (frame_valid),
    .interrupt    (interrupt),
    .count        (count),
    .drop_count   (drop_count)
  );

  initial sampling_clk = 1'b0;
  always #5 sampling_clk = ~sampling_clk;

  function automatic logic [63:0] refof(input logic [15:0] id);
    return {32'hC0DE_0000, 16'h0000, id};
  endfunction

  function automatic logic [23:0] datof(input logic [15:0] id);
    return {8'h5A, id};
  endfunction

  function automatic logic [127:0] mk(input logic [15:0] id, input logic [7:0] tag);
    return {8'h7E, id, refof(id), datof(id), tag, 8'h7D};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge sampling_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] id);
    trig_valid = 1'b1;
    trigger_id = id;
    ref_v      = refof(id);
    data_in    = datof(id);
    tick();
    trig_valid = 1'b0;
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!frame_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_valid", 128'(frame_valid), 128'd1);
  endtask

  task automatic read_one(input bit more);
    wait_valid();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("gap_low", 128'(frame_valid), 128'd0);
    chk("gap_irq", 128'(interrupt), 128'd1);
    tick();
    chk("next_head", 128'(frame_valid), 128'(more));
  endtask

  // Monitor: every rising frame_valid presents a new head to compare.
  always @(negedge sampling_clk) begin
    if (frame_valid && !prev_fv) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL head_unexpected actual=%h expected=none", frame);
      end else begin
        chk("head_frame", frame, sb.pop_front());
      end
    end
    prev_fv = frame_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; trig_valid = 1'b0; trigger_id = '0; ref_v = '0; data_in = '0;
    flush = 1'b0; frame_ack = 1'b0;
    repeat (3) @(posedge sampling_clk);
    #1 reset = 1'b0;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_valid", 128'(frame_valid), 128'd0);
    chk("rst_irq", 128'(interrupt), 128'd1);
    chk("rst_drop", 128'(drop_count), 128'd0);
    chk("rst_frame", frame, IDLE);

    // Single trigger
    sb.push_back(128'h7E_1234_00000000000000AB_A5A5A5_00_7D);
    trig_valid = 1'b1; trigger_id = 16'h1234; ref_v = 64'h0000_0000_0000_00AB; data_in = 24'hA5A5A5;
    tick();
    trig_valid = 1'b0;
    chk("single_count", 128'(count), 128'd1);
    chk("single_lat", 128'(frame_valid), 128'd0);
    tick();
    chk("single_valid", 128'(frame_valid), 128'd1);
    chk("single_irq", 128'(interrupt), 128'd0);
    chk("single_frame", frame, 128'h7E_1234_00000000000000AB_A5A5A5_00_7D);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("single_idle", frame, IDLE);
    chk("single_irq_hi", 128'(interrupt), 128'd1);
    chk("single_empty", 128'(count), 128'd0);

    // Ordering
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(mk(16'(i), 8'h00));
      send(16'(i));
    end
    read_one(1'b1);
    read_one(1'b1);
    read_one(1'b0);

    // Overflow: ids 9..11 are dropped
    for (int i = 1; i <= 11; i++) begin
      if (i <= 8) sb.push_back(mk(16'(i), 8'h00));
      send(16'(i));
    end
    chk("ovf_count", 128'(count), 128'd8);
    chk("ovf_drop", 128'(drop_count), 128'd3);

    // Full with simultaneous pop and write
    sb.push_back(mk(16'd12, TAG_EN ? 8'h03 : 8'h00));
    trig_valid = 1'b1; trigger_id = 16'd12; ref_v = refof(16'd12); data_in = datof(16'd12);
    frame_ack = 1'b1;
    tick();
    trig_valid = 1'b0; frame_ack = 1'b0;
    chk("fullpop_count", 128'(count), 128'd8);
    chk("fullpop_drop", 128'(drop_count), 128'd3);
    for (int k = 0; k < 8; k++) read_one(k < 7);
    chk("drain_count", 128'(count), 128'd0);

    // Ack on empty
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack_empty_count", 128'(count), 128'd0);
    chk("ack_empty_valid", 128'(frame_valid), 128'd0);
    chk("ack_empty_frame", frame, IDLE);

    // Empty with trigger and ack together: write proceeds
    sb.push_back(mk(16'h0055, 8'h00));
    trig_valid = 1'b1; trigger_id = 16'h0055; ref_v = refof(16'h0055); data_in = datof(16'h0055);
    frame_ack = 1'b1;
    tick();
    trig_valid = 1'b0; frame_ack = 1'b0;
    chk("empty_trig_ack_count", 128'(count), 128'd1);
    read_one(1'b0);

    // Flush with 5 stored plus simultaneous trigger and ack
    sb.push_back(mk(16'h0021, 8'h00));
    for (int i = 16'h21; i <= 16'h25; i++) send(16'(i));
    chk("pre_flush_count", 128'(count), 128'd5);
    flush = 1'b1; frame_ack = 1'b1;
    trig_valid = 1'b1; trigger_id = 16'h0099; ref_v = refof(16'h0099); data_in = datof(16'h0099);
    tick();
    flush = 1'b0; frame_ack = 1'b0; trig_valid = 1'b0;
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_valid", 128'(frame_valid), 128'd0);
    chk("flush_irq", 128'(interrupt), 128'd1);
    chk("flush_frame", frame, IDLE);
    chk("flush_drop", 128'(drop_count), 128'd3);
    tick();
    tick();
    chk("flush_no_write", 128'(frame_valid), 128'd0);
    chk("flush_no_count", 128'(count), 128'd0);

    // Asynchronous reset with 4 stored
    sb.push_back(mk(16'h0041, 8'h00));
    for (int i = 16'h41; i <= 16'h44; i++) send(16'(i));
    chk("pre_reset_count", 128'(count), 128'd4);
    #3 reset = 1'b1;
    #2;
    chk("arst_count", 128'(count), 128'd0);
    chk("arst_valid", 128'(frame_valid), 128'd0);
    chk("arst_irq", 128'(interrupt), 128'd1);
    chk("arst_drop", 128'(drop_count), 128'd0);
    chk("arst_frame", frame, IDLE);
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_valid", 128'(frame_valid), 128'd0);

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
